tracer_mc_reg_if: RTL and testbench

//  Multi-channel APB-side register file for the tracer uDMA RX path, with NUM_CH independent channels.
//  Per channel: start address, size, datasize, continuous, filter. Generates one-cycle enable and clear pulses.

---
 rtl/tracer_reg_pkg.sv | 39 +++
 rtl/tracer_ch_regs.sv | 54 +++++
 rtl/tracer_mc_reg_if.sv | 118 +++++++++++
 tb/tb_tracer_mc_reg_if.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tracer_reg_pkg.sv
// rtl/tracer_reg_pkg.sv - register map constants and channel config type for the tracer RX register file
package tracer_reg_pkg;

  localparam int TRACER_AW = 12;
  localparam int TRACER_TS = 16;

  localparam logic [2:0] TRACER_GLOBAL_BLK = 3'd7;

  localparam logic [1:0] REG_SADDR  = 2'd0;
  localparam logic [1:0] REG_SIZE   = 2'd1;
  localparam logic [1:0] REG_CFG    = 2'd2;
  localparam logic [1:0] REG_INTCFG = 2'd3;

  localparam logic [1:0] GREG_IRQ_STATUS = 2'd0;
  localparam logic [1:0] GREG_IRQ_PEND   = 2'd1;

  localparam int CFG_CONT_BIT   = 0;
  localparam int CFG_DS_LSB     = 1;
  localparam int CFG_FILTER_BIT = 3;
  localparam int CFG_EN_BIT     = 4;
  localparam int CFG_CLR_BIT    = 5;

  localparam int IRQ_OVF_LSB = 8;

  typedef struct packed {
    logic [TRACER_AW-1:0] startaddr;
    logic [TRACER_TS-1:0] size;
    logic [1:0]           datasize;
    logic                 continuous;
    logic                 filter;
    logic [1:0]           irq_en;
  } tracer_ch_cfg_t;

  // CFG readback mixes live channel status with stored config bits.
  function automatic logic [31:0] cfg_readback(tracer_ch_cfg_t c, logic busy, logic pend);
    return {26'd0, pend, busy, c.filter, c.datasize, c.continuous};
  endfunction

endpackage

// File: rtl/tracer_ch_regs.sv
// rtl/tracer_ch_regs.sv - one RX channel: config registers, en/clr pulses, overflow detect
module tracer_ch_regs
  import tracer_reg_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           wr,
  input  logic [1:0]     wr_reg,
  input  logic [31:0]    wdata,
  input  logic           pending,
  output tracer_ch_cfg_t cfg,
  output logic           en_pulse,
  output logic           clr_pulse,
  output logic           ovf_set
);

  logic wr_cfg;
  logic req_en;
  logic req_clr;
  logic unused_wdata;

  assign wr_cfg       = wr && (wr_reg == REG_CFG);
  assign req_en       = wdata[CFG_EN_BIT];
  assign req_clr      = wdata[CFG_CLR_BIT];
  assign unused_wdata = ^wdata;

  // Clear wins over enable; an enable into a full queue is dropped and flagged instead.
  assign ovf_set = wr_cfg & req_en & ~req_clr & pending;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg       <= '0;
      en_pulse  <= 1'b0;
      clr_pulse <= 1'b0;
    end else begin
      en_pulse  <= wr_cfg & req_en & ~req_clr & ~pending;
      clr_pulse <= wr_cfg & req_clr;
      if (wr) begin
        case (wr_reg)
          REG_SADDR:  cfg.startaddr <= wdata[TRACER_AW-1:0];
          REG_SIZE:   cfg.size      <= wdata[TRACER_TS-1:0];
          REG_CFG: begin
            cfg.continuous <= wdata[CFG_CONT_BIT];
            cfg.datasize   <= wdata[CFG_DS_LSB +: 2];
            cfg.filter     <= wdata[CFG_FILTER_BIT];
          end
          REG_INTCFG: cfg.irq_en    <= wdata[1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/tracer_mc_reg_if.sv
// rtl/tracer_mc_reg_if.sv - multi-channel tracer uDMA RX register file with read mux, irq flags and irq_o
module tracer_mc_reg_if
  import tracer_reg_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int L2_AWIDTH_NOAL = TRACER_AW,
  parameter int TRANS_SIZE     = TRACER_TS
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [31:0]                           cfg_data_i,
  input  logic [4:0]                            cfg_addr_i,
  input  logic                                  cfg_valid_i,
  input  logic                                  cfg_rw_ni,
  output logic [31:0]                           cfg_data_o,
  output logic                                  cfg_ready_o,
  output logic [NUM_CH-1:0][L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
  output logic [NUM_CH-1:0][TRANS_SIZE-1:0]     cfg_rx_size_o,
  output logic [NUM_CH-1:0][1:0]                cfg_rx_datasize_o,
  output logic [NUM_CH-1:0]                     cfg_rx_continuous_o,
  output logic [NUM_CH-1:0]                     cfg_rx_filter_o,
  output logic [NUM_CH-1:0]                     cfg_rx_en_o,
  output logic [NUM_CH-1:0]                     cfg_rx_clr_o,
  input  logic [NUM_CH-1:0]                     cfg_rx_en_i,
  input  logic [NUM_CH-1:0]                     cfg_rx_pending_i,
  input  logic [NUM_CH-1:0][L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
  input  logic [NUM_CH-1:0][TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
  input  logic [NUM_CH-1:0]                     ch_done_i,
  output logic                                  irq_o
);

  logic [2:0]  blk;
  logic [1:0]  regsel;
  logic        wr_acc;
  logic        w1c;

  tracer_ch_cfg_t    ch_cfg [NUM_CH];
  logic [NUM_CH-1:0] ovf_set;
  logic [NUM_CH-1:0] done_en;
  logic [NUM_CH-1:0] ovf_en;
  logic [NUM_CH-1:0] done_clr;
  logic [NUM_CH-1:0] ovf_clr;
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] ovf_q;
  logic [31:0]       irq_status;
  logic [31:0]       irq_pend;

  assign blk         = cfg_addr_i[4:2];
  assign regsel      = cfg_addr_i[1:0];
  assign wr_acc      = cfg_valid_i & ~cfg_rw_ni;
  assign cfg_ready_o = 1'b1;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tracer_ch_regs u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr        (wr_acc && (blk == 3'(i))),
      .wr_reg    (regsel),
      .wdata     (cfg_data_i),
      .pending   (cfg_rx_pending_i[i]),
      .cfg       (ch_cfg[i]),
      .en_pulse  (cfg_rx_en_o[i]),
      .clr_pulse (cfg_rx_clr_o[i]),
      .ovf_set   (ovf_set[i])
    );

    assign cfg_rx_startaddr_o[i]  = ch_cfg[i].startaddr;
    assign cfg_rx_size_o[i]       = ch_cfg[i].size;
    assign cfg_rx_datasize_o[i]   = ch_cfg[i].datasize;
    assign cfg_rx_continuous_o[i] = ch_cfg[i].continuous;
    assign cfg_rx_filter_o[i]     = ch_cfg[i].filter;
    assign done_en[i]             = ch_cfg[i].irq_en[0];
    assign ovf_en[i]              = ch_cfg[i].irq_en[1];
  end

  assign w1c      = wr_acc && (blk == TRACER_GLOBAL_BLK) && (regsel == GREG_IRQ_STATUS);
  assign done_clr = w1c ? cfg_data_i[NUM_CH-1:0] : '0;
  assign ovf_clr  = w1c ? cfg_data_i[IRQ_OVF_LSB +: NUM_CH] : '0;

  // Set terms are OR-ed after the clear so a same-cycle event is never lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= '0;
      ovf_q  <= '0;
      irq_o  <= 1'b0;
    end else begin
      done_q <= (done_q & ~done_clr) | ch_done_i;
      ovf_q  <= (ovf_q & ~ovf_clr) | ovf_set;
      irq_o  <= |((done_q & done_en) | (ovf_q & ovf_en));
    end
  end

  assign irq_status = {16'd0, 8'(ovf_q), 8'(done_q)};
  assign irq_pend   = {16'd0, 8'(ovf_q & ovf_en), 8'(done_q & done_en)};

  always_comb begin
    cfg_data_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (blk == 3'(i)) begin
        case (regsel)
          REG_SADDR:  cfg_data_o = 32'(cfg_rx_curr_addr_i[i]);
          REG_SIZE:   cfg_data_o = 32'(cfg_rx_bytes_left_i[i]);
          REG_CFG:    cfg_data_o = cfg_readback(ch_cfg[i], cfg_rx_en_i[i], cfg_rx_pending_i[i]);
          REG_INTCFG: cfg_data_o = {30'd0, ch_cfg[i].irq_en};
          default:    cfg_data_o = '0;
        endcase
      end
    end
    if (blk == TRACER_GLOBAL_BLK) begin
      case (regsel)
        GREG_IRQ_STATUS: cfg_data_o = irq_status;
        GREG_IRQ_PEND:   cfg_data_o = irq_pend;
        default:         cfg_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tracer_mc_reg_if.sv
// tb/tb_tracer_mc_reg_if.sv - directed self-checking bench for tracer_mc_reg_if
module tb_tracer_mc_reg_if;

  localparam int NCH = 2;
  localparam int AW  = 12;
  localparam int TS  = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [31:0]              cfg_data = '0;
  logic [4:0]               cfg_addr = '0;
  logic                     cfg_valid = 1'b0;
  logic                     cfg_rw_n = 1'b1;
  logic [31:0]              cfg_data_o;
  logic                     cfg_ready;
  logic [NCH-1:0][AW-1:0]   startaddr;
  logic [NCH-1:0][TS-1:0]   size;
  logic [NCH-1:0][1:0]      datasize;
  logic [NCH-1:0]           continuous;
  logic [NCH-1:0]           filter;
  logic [NCH-1:0]           en_o;
  logic [NCH-1:0]           clr_o;
  logic [NCH-1:0]           busy = '0;
  logic [NCH-1:0]           pending = '0;
  logic [NCH-1:0][AW-1:0]   curr_addr = '0;
  logic [NCH-1:0][TS-1:0]   bytes_left = '0;
  logic [NCH-1:0]           ch_done = '0;
  logic                     irq;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] rd;

  tracer_mc_reg_if #(.NUM_CH(NCH), .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .cfg_data_i          (cfg_data),
    .cfg_addr_i          (cfg_addr),
    .cfg_valid_i         (cfg_valid),
    .cfg_rw_ni           (cfg_rw_n),
    .cfg_data_o          (cfg_data_o),
    .cfg_ready_o         (cfg_ready),
    .cfg_rx_startaddr_o  (startaddr),
    .cfg_rx_size_o       (size),
    .cfg_rx_datasize_o   (datasize),
    .cfg_rx_continuous_o (continuous),
    .cfg_rx_filter_o     (filter),
    .cfg_rx_en_o         (en_o),
    .cfg_rx_clr_o        (clr_o),
    .cfg_rx_en_i         (busy),
    .cfg_rx_pending_i    (pending),
    .cfg_rx_curr_addr_i  (curr_addr),
    .cfg_rx_bytes_left_i (bytes_left),
    .ch_done_i           (ch_done),
    .irq_o               (irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cfg_addr  = a;
    cfg_data  = d;
    cfg_rw_n  = 1'b0;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_rw_n  = 1'b1;
  endtask

  task automatic rdreg(input logic [4:0] a, output logic [31:0] d);
    cfg_addr  = a;
    cfg_rw_n  = 1'b1;
    cfg_valid = 1'b1;
    #1;
    d = cfg_data_o;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    tests_run++; if (en_o !== 2'b00 || clr_o !== 2'b00) begin tests_failed++; $display("FAIL reset_pulses en=%b clr=%b required 00/00", en_o, clr_o); end
    tests_run++; if (startaddr !== '0 || size !== '0 || datasize !== '0 || continuous !== '0 || filter !== '0) begin tests_failed++; $display("FAIL reset_cfg sa=%h sz=%h required 0", startaddr, size); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq got %b required 0", irq); end
    rdreg(5'h02, rd);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_cfg_read got %h required 0", rd); end
    tests_run++; if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL ready got %b required 1", cfg_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_config_en();
    wr(5'h04, 32'h123);
    wr(5'h05, 32'h40);
    wr(5'h06, 32'h17);
    tests_run++; if (startaddr[1] !== 12'h123 || size[1] !== 16'h40) begin tests_failed++; $display("FAIL cfg_addr_size sa=%h sz=%h required 123/0040", startaddr[1], size[1]); end
    tests_run++; if (datasize[1] !== 2'd3 || continuous[1] !== 1'b1 || filter[1] !== 1'b0) begin tests_failed++; $display("FAIL cfg_bits ds=%0d cont=%b flt=%b required 3/1/0", datasize[1], continuous[1], filter[1]); end
    tests_run++; if (startaddr[0] !== 12'h0) begin tests_failed++; $display("FAIL cfg_ch0_untouched sa=%h required 000", startaddr[0]); end
    tests_run++; if (en_o !== 2'b10 || clr_o !== 2'b00) begin tests_failed++; $display("FAIL en_pulse en=%b clr=%b required 10/00", en_o, clr_o); end
    step();
    tests_run++; if (en_o !== 2'b00) begin tests_failed++; $display("FAIL en_pulse_width en=%b required 00", en_o); end
    rdreg(5'h06, rd);
    tests_run++; if (rd !== 32'h7) begin tests_failed++; $display("FAIL cfg_read got %h required 00000007", rd); end
    curr_addr[1]  = 12'hABC;
    bytes_left[1] = 16'h1234;
    rdreg(5'h04, rd);
    tests_run++; if (rd !== 32'hABC) begin tests_failed++; $display("FAIL saddr_read got %h required 00000abc", rd); end
    rdreg(5'h05, rd);
    tests_run++; if (rd !== 32'h1234) begin tests_failed++; $display("FAIL size_read got %h required 00001234", rd); end
    busy[1] = 1'b1;
    wr(5'h06, 32'h10);
    tests_run++; if (en_o !== 2'b10) begin tests_failed++; $display("FAIL en_while_busy en=%b required 10", en_o); end
    rdreg(5'h06, rd);
    tests_run++; if (rd !== 32'h10) begin tests_failed++; $display("FAIL cfg_read_busy got %h required 00000010", rd); end
    busy[1] = 1'b0;
    step();
  endtask

  task automatic test_clr_priority();
    wr(5'h02, 32'h30);
    tests_run++; if (clr_o !== 2'b01 || en_o !== 2'b00) begin tests_failed++; $display("FAIL clr_prio clr=%b en=%b required 01/00", clr_o, en_o); end
    step();
    tests_run++; if (clr_o !== 2'b00 || en_o !== 2'b00) begin tests_failed++; $display("FAIL clr_width clr=%b en=%b required 00/00", clr_o, en_o); end
    rdreg(5'h1C, rd);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL clr_no_ovf status=%h required 0", rd); end
  endtask

  task automatic test_overflow();
    pending[0] = 1'b1;
    wr(5'h02, 32'h10);
    tests_run++; if (en_o !== 2'b00) begin tests_failed++; $display("FAIL ovf_no_en en=%b required 00", en_o); end
    rdreg(5'h1C, rd);
    tests_run++; if (rd !== 32'h100) begin tests_failed++; $display("FAIL ovf_status got %h required 00000100", rd); end
    pending[0] = 1'b0;
    wr(5'h03, 32'h2);
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL ovf_irq_early got %b required 0", irq); end
    step();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL ovf_irq got %b required 1", irq); end
    rdreg(5'h1D, rd);
    tests_run++; if (rd !== 32'h100) begin tests_failed++; $display("FAIL ovf_pend got %h required 00000100", rd); end
    wr(5'h1C, 32'h100);
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL ovf_irq_hold got %b required 1", irq); end
    step();
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL ovf_irq_clear got %b required 0", irq); end
  endtask

  task automatic test_done_collision();
    wr(5'h07, 32'h1);
    ch_done = 2'b10;
    step();
    ch_done = 2'b00;
    rdreg(5'h1C, rd);
    tests_run++; if (rd !== 32'h2) begin tests_failed++; $display("FAIL done_status got %h required 00000002", rd); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL done_irq_early got %b required 0", irq); end
    step();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL done_irq got %b required 1", irq); end
    ch_done = 2'b10;
    wr(5'h1C, 32'h2);
    ch_done = 2'b00;
    rdreg(5'h1C, rd);
    tests_run++; if (rd !== 32'h2) begin tests_failed++; $display("FAIL collision_set_wins got %h required 00000002", rd); end
    wr(5'h1C, 32'h2);
    rdreg(5'h1C, rd);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL done_w1c got %h required 0", rd); end
    step();
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL done_irq_clear got %b required 0", irq); end
  endtask

  task automatic test_decode_holes();
    wr(5'h10, 32'hFFFF_FFFF);
    tests_run++; if (en_o !== 2'b00 || clr_o !== 2'b00) begin tests_failed++; $display("FAIL hole_pulse_a en=%b clr=%b required 00/00", en_o, clr_o); end
    wr(5'h12, 32'h3F);
    tests_run++; if (en_o !== 2'b00 || clr_o !== 2'b00) begin tests_failed++; $display("FAIL hole_pulse_b en=%b clr=%b required 00/00", en_o, clr_o); end
    rdreg(5'h12, rd);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL hole_read_blk4 got %h required 0", rd); end
    wr(5'h1F, 32'hFFFF_FFFF);
    rdreg(5'h1F, rd);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL hole_read_greg3 got %h required 0", rd); end
    rdreg(5'h1E, rd);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL hole_read_greg2 got %h required 0", rd); end
    tests_run++; if (startaddr[1] !== 12'h123 || startaddr[0] !== 12'h0 || size[1] !== 16'h40) begin tests_failed++; $display("FAIL hole_no_change sa1=%h sa0=%h sz1=%h required 123/000/0040", startaddr[1], startaddr[0], size[1]); end
    step();
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL hole_irq got %b required 0", irq); end
  endtask

  task automatic test_reset_mid();
    wr(5'h04, 32'h5A5);
    tests_run++; if (startaddr[1] !== 12'h5A5) begin tests_failed++; $display("FAIL pre_reset_sa got %h required 5a5", startaddr[1]); end
    cfg_addr  = 5'h06;
    cfg_data  = 32'h1F;
    cfg_rw_n  = 1'b0;
    cfg_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (startaddr !== '0 || irq !== 1'b0) begin tests_failed++; $display("FAIL async_reset sa=%h irq=%b required 0/0", startaddr, irq); end
    step();
    tests_run++; if (en_o !== 2'b00 || datasize !== '0 || continuous !== '0 || filter !== '0) begin tests_failed++; $display("FAIL reset_abort en=%b ds=%b required 00/0", en_o, datasize); end
    cfg_valid = 1'b0;
    cfg_rw_n  = 1'b1;
    rst_n     = 1'b1;
    step();
    tests_run++; if (en_o !== 2'b00) begin tests_failed++; $display("FAIL post_reset_en en=%b required 00", en_o); end
    rdreg(5'h03, rd);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_intcfg got %h required 0", rd); end
  endtask

  initial begin
    test_reset();
    test_config_en();
    test_clr_priority();
    test_overflow();
    test_done_collision();
    test_decode_holes();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
